// File: rtl/fact_pkg.sv
// Shared types and default widths for the factorial sequencer.
package fact_pkg;

  localparam int K_W_DEF   = 9;
  localparam int ACC_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_STEP = 3'd3,
    S_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/fact_mul_iter.sv
// Iterative shift-add multiplier: one bit of b per cycle, LSB first.
module fact_mul_iter #(
  parameter int ACC_W = 32,
  parameter int K_W   = 9
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [ACC_W-1:0]     a,
  input  logic [K_W-1:0]       b,
  output logic                 done,
  output logic [ACC_W+K_W-1:0] p,
  output logic                 ovf
);

  localparam int PW = ACC_W + K_W;
  localparam int RW = $clog2(K_W + 1);

  logic [PW-1:0]  p_q, p_d;
  logic [PW-1:0]  mc_q, mc_d;
  logic [K_W-1:0] mp_q, mp_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic           run_q, run_d;

  always_comb begin
    p_d   = p_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    rem_d = rem_q;
    run_d = run_q;
    if (start) begin
      // bit 0 is folded in on the start edge itself
      p_d   = b[0] ? {{K_W{1'b0}}, a} : '0;
      mc_d  = {{K_W{1'b0}}, a} << 1;
      mp_d  = b >> 1;
      rem_d = RW'(K_W - 1);
      run_d = (K_W > 1);
    end else if (run_q) begin
      if (mp_q[0]) p_d = p_q + mc_q;
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      rem_d = rem_q - RW'(1);
      run_d = (rem_q != RW'(1));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      p_q   <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      rem_q <= '0;
      run_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      rem_q <= rem_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (rem_q == RW'(1));
  assign p    = p_q;
  assign ovf  = |p_q[PW-1:ACC_W];

endmodule

// File: rtl/fact_seq_ctrl.sv
// Factorial sequencer: down counter from N to 1, each count
// multiplied into ACC by the iterative multiplier.
module fact_seq_ctrl
  import fact_pkg::*;
#(
  parameter int K_W   = K_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [K_W-1:0]   N,
  output logic             BUSY,
  output logic             DONE,
  output logic [ACC_W-1:0] RESULT,
  output logic             OVF,
  output logic [K_W-1:0]   CNT_Q
);

  localparam int PW = ACC_W + K_W;

  state_t           state_q, state_d;
  logic [K_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             mst_q, mst_d;

  logic             mul_start;
  logic             mul_done;
  logic [PW-1:0]    mul_p;
  logic             mul_ovf;
  logic             ovf_hit;

  fact_mul_iter #(
    .ACC_W (ACC_W),
    .K_W   (K_W)
  ) u_mul (
    .CLK   (CLK),
    .RST   (RST),
    .start (mul_start),
    .a     (acc_q),
    .b     (cnt_q),
    .done  (mul_done),
    .p     (mul_p),
    .ovf   (mul_ovf)
  );

  assign ovf_hit = mul_ovf | (|mul_p[PW-1:ACC_W]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    mst_d     = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          cnt_d   = N;
          res_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        acc_d   = ACC_W'(1);
        state_d = (cnt_q <= K_W'(1)) ? S_FIN : S_MUL;
      end
      S_MUL: begin
        // start pulses only on the first MUL cycle of each step
        mst_d     = 1'b1;
        mul_start = !mst_q;
        if (mul_done) state_d = S_STEP;
      end
      S_STEP: begin
        acc_d = mul_p[ACC_W-1:0];
        cnt_d = cnt_q - K_W'(1);
        if (ovf_hit) begin
          ovf_d   = 1'b1;
          state_d = S_FIN;
        end else if (cnt_d == K_W'(1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_MUL;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        res_d   = ovf_q ? '0 : acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      mst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      mst_q   <= mst_d;
    end
  end

  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = done_q;
  assign RESULT = res_q;
  assign OVF    = ovf_q;
  assign CNT_Q  = cnt_q;

endmodule
